// File: rtl/accel_run_ctrl.sv
// Run sequencer for the MNIST accelerator: resets the accelerator, waits for the
// image stream to finish (or time out), then serially scans ten signed scores for the argmax.
module accel_run_ctrl #(
    parameter int W             = 32,
    parameter int RST_CYCLES    = 2,
    parameter int END_COUNT     = 784,
    parameter int SETTLE_CYCLES = 40,
    parameter int TIMEOUT       = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         accel_reset,
    input  logic [W-1:0] counter1,
    input  logic [W-1:0] result0,
    input  logic [W-1:0] result1,
    input  logic [W-1:0] result2,
    input  logic [W-1:0] result3,
    input  logic [W-1:0] result4,
    input  logic [W-1:0] result5,
    input  logic [W-1:0] result6,
    input  logic [W-1:0] result7,
    input  logic [W-1:0] result8,
    input  logic [W-1:0] result9,
    output logic         busy,
    output logic         done,
    output logic         timed_out,
    output logic [3:0]   class_id,
    output logic [W-1:0] max_score,
    output logic [15:0]  run_cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [W-1:0] RST_LAST    = W'(RST_CYCLES - 1);
    localparam logic [W-1:0] SETTLE_LAST = W'(SETTLE_CYCLES - 1);
    localparam logic [W-1:0] RUN_LAST    = W'(TIMEOUT - 1);
    localparam logic [W-1:0] END_VAL     = W'(END_COUNT);
    localparam logic [W-1:0] SAT_LIMIT   = W'(32'h0000_FFFF);
    localparam logic [3:0]   CLASS_NONE  = 4'hF;
    localparam logic [3:0]   LAST_IDX    = 4'd9;

    logic [2:0]   state_q,      state_d;
    logic [W-1:0] cnt_q,        cnt_d;
    logic [3:0]   idx_q,        idx_d;
    logic [W-1:0] best_q,       best_d;
    logic [3:0]   bidx_q,       bidx_d;
    logic         timed_out_q,  timed_out_d;
    logic [3:0]   class_id_q,   class_id_d;
    logic [W-1:0] max_score_q,  max_score_d;
    logic [15:0]  run_cycles_q, run_cycles_d;

    logic [W-1:0] cnt_inc;
    logic [W-1:0] cur_score;
    logic         scan_take;
    logic [W-1:0] best_nxt;
    logic [3:0]   bidx_nxt;

    function automatic logic [15:0] sat16(input logic [W-1:0] v);
        return (v > SAT_LIMIT) ? 16'hFFFF : v[15:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_score = '0;
        case (idx_q)
            4'd0:    cur_score = result0;
            4'd1:    cur_score = result1;
            4'd2:    cur_score = result2;
            4'd3:    cur_score = result3;
            4'd4:    cur_score = result4;
            4'd5:    cur_score = result5;
            4'd6:    cur_score = result6;
            4'd7:    cur_score = result7;
            4'd8:    cur_score = result8;
            4'd9:    cur_score = result9;
            default: cur_score = '0;
        endcase
    end

    // Strict compare so ties keep the lower class index.
    assign scan_take = (idx_q == 4'd0) || ($signed(cur_score) > $signed(best_q));
    assign best_nxt  = scan_take ? cur_score : best_q;
    assign bidx_nxt  = scan_take ? idx_q : bidx_q;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        best_d       = best_q;
        bidx_d       = bidx_q;
        timed_out_d  = timed_out_q;
        class_id_d   = class_id_q;
        max_score_d  = max_score_q;
        run_cycles_d = run_cycles_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RST;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    class_id_d  = CLASS_NONE;
                    max_score_d = '0;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                // Completion is checked before the timeout so it wins on a tie.
                if (counter1 == END_VAL) begin
                    state_d      = S_SETTLE;
                    run_cycles_d = sat16(cnt_q);
                    cnt_d        = '0;
                end else if (cnt_q == RUN_LAST) begin
                    state_d      = S_DONE;
                    timed_out_d  = 1'b1;
                    class_id_d   = CLASS_NONE;
                    max_score_d  = '0;
                    run_cycles_d = sat16(cnt_inc);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SCAN: begin
                best_d = best_nxt;
                bidx_d = bidx_nxt;
                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    class_id_d  = bidx_nxt;
                    max_score_d = best_nxt;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            bidx_q       <= '0;
            timed_out_q  <= 1'b0;
            class_id_q   <= CLASS_NONE;
            max_score_q  <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            bidx_q       <= bidx_d;
            timed_out_q  <= timed_out_d;
            class_id_q   <= class_id_d;
            max_score_q  <= max_score_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Accelerator is released only while it computes or holds its scores for the scan.
    assign accel_reset = !((state_q == S_RUN) || (state_q == S_SETTLE) || (state_q == S_SCAN));
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign timed_out   = timed_out_q;
    assign class_id    = class_id_q;
    assign max_score   = max_score_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Directed bench for accel_run_ctrl: table of inference runs plus hand-written
// start-while-busy and reset-mid-scan sequences, with a small accelerator counter model.
module tb_accel_run_ctrl;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              accel_reset;
    logic [31:0]       counter1;
    logic [9:0][31:0]  res;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [3:0]        class_id;
    logic [31:0]       max_score;
    logic [15:0]       run_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int rc       = 0;
    int target   = 32'h7FFF_FFFF;

    typedef struct {
        logic [9:0][31:0] res;
        int               target;
        bit               inject;
        logic [3:0]       exp_class;
        logic [31:0]      exp_score;
        logic             exp_to;
        logic [15:0]      exp_rc;
        bit               chk_rc;
        int               exp_lat;
    } vec_t;

    vec_t vecs [6];

    accel_run_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .accel_reset (accel_reset),
        .counter1    (counter1),
        .result0     (res[0]),
        .result1     (res[1]),
        .result2     (res[2]),
        .result3     (res[3]),
        .result4     (res[4]),
        .result5     (res[5]),
        .result6     (res[6]),
        .result7     (res[7]),
        .result8     (res[8]),
        .result9     (res[9]),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .class_id    (class_id),
        .max_score   (max_score),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    // Accelerator model: counts cycles out of reset, shows 784 once rc reaches target.
    always @(posedge clk) begin
        if (accel_reset) rc <= 0;
        else             rc <= rc + 1;
    end
    assign counter1 = (rc >= target) ? 32'd784 : 32'(rc % 784);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        res    = v.res;
        target = v.target;
        pulse_start();
        check($sformatf("v%0d done_clear", id), 32'(done), 32'd0);
        check($sformatf("v%0d busy", id), 32'(busy), 32'd1);
        check($sformatf("v%0d rst_hold0", id), 32'(accel_reset), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d rst_hold1", id), 32'(accel_reset), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d rst_release", id), 32'(accel_reset), 32'd0);
        lat = 2;
        while (!done && lat < 3000) begin
            start = v.inject && (lat == 100 || lat == 846);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d done", id), 32'(done), 32'd1);
        check($sformatf("v%0d busy_low", id), 32'(busy), 32'd0);
        check($sformatf("v%0d accel_reset", id), 32'(accel_reset), 32'd1);
        check($sformatf("v%0d timed_out", id), 32'(timed_out), 32'(v.exp_to));
        check($sformatf("v%0d class_id", id), 32'(class_id), 32'(v.exp_class));
        check($sformatf("v%0d max_score", id), max_score, v.exp_score);
        if (v.chk_rc)
            check($sformatf("v%0d run_cycles", id), 32'(run_cycles), 32'(v.exp_rc));
        @(negedge clk);
        check($sformatf("v%0d done_sticky", id), 32'(done), 32'd1);
    endtask

    initial begin
        int lat;

        // v0: normal run, result3 highest
        for (int i = 0; i < 10; i++) vecs[0].res[i] = 32'(i * 256);
        vecs[0].res[3]   = 32'h0000_1234;
        vecs[0].target   = 800;  vecs[0].inject  = 1'b0;
        vecs[0].exp_class = 4'd3; vecs[0].exp_score = 32'h0000_1234;
        vecs[0].exp_to   = 1'b0; vecs[0].exp_rc  = 16'd800; vecs[0].chk_rc = 1'b1;
        vecs[0].exp_lat  = 853;
        // v1: same run with extra start pulses during RUN and SCAN
        vecs[1] = vecs[0];
        vecs[1].inject   = 1'b1;
        // v2: signed scores with a tie between 5 and 7
        for (int i = 0; i < 10; i++) vecs[2].res[i] = 32'hFFFF_FFF0 - 32'(i);
        vecs[2].res[0]   = 32'hFFFF_FF00;
        vecs[2].res[5]   = 32'h0000_0010;
        vecs[2].res[7]   = 32'h0000_0010;
        vecs[2].target   = 50;   vecs[2].inject  = 1'b0;
        vecs[2].exp_class = 4'd5; vecs[2].exp_score = 32'h0000_0010;
        vecs[2].exp_to   = 1'b0; vecs[2].exp_rc  = 16'd50; vecs[2].chk_rc = 1'b1;
        vecs[2].exp_lat  = 103;
        // v3: all scores most negative, completion on first RUN cycle
        for (int i = 0; i < 10; i++) vecs[3].res[i] = 32'h8000_0000;
        vecs[3].target   = 0;    vecs[3].inject  = 1'b0;
        vecs[3].exp_class = 4'd0; vecs[3].exp_score = 32'h8000_0000;
        vecs[3].exp_to   = 1'b0; vecs[3].exp_rc  = 16'd0; vecs[3].chk_rc = 1'b1;
        vecs[3].exp_lat  = 53;
        // v4: result9 highest, completion coincides with the timeout cycle
        for (int i = 0; i < 10; i++) vecs[4].res[i] = 32'(i * 3);
        vecs[4].res[9]   = 32'h7FFF_FFFF;
        vecs[4].target   = 999;  vecs[4].inject  = 1'b0;
        vecs[4].exp_class = 4'd9; vecs[4].exp_score = 32'h7FFF_FFFF;
        vecs[4].exp_to   = 1'b0; vecs[4].exp_rc  = 16'd999; vecs[4].chk_rc = 1'b1;
        vecs[4].exp_lat  = 1052;
        // v5: timeout, counter never reaches 784 within the RUN window
        vecs[5]          = vecs[0];
        vecs[5].target   = 1000;
        vecs[5].exp_class = 4'hF; vecs[5].exp_score = 32'h0000_0000;
        vecs[5].exp_to   = 1'b1; vecs[5].chk_rc  = 1'b0;
        vecs[5].exp_lat  = 1002;

        reset = 1'b1;
        start = 1'b0;
        res   = '0;
        repeat (2) @(negedge clk);
        check("rst accel_reset", 32'(accel_reset), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst timed_out", 32'(timed_out), 32'd0);
        check("rst class_id", 32'(class_id), 32'hF);
        check("rst max_score", max_score, 32'd0);
        check("rst run_cycles", 32'(run_cycles), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle accel_reset", 32'(accel_reset), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset asserted while scanning index 4
        res    = vecs[0].res;
        target = vecs[0].target;
        pulse_start();
        lat = 0;
        while (lat < 847) begin
            @(negedge clk);
            lat++;
        end
        check("mid busy", 32'(busy), 32'd1);
        check("mid accel_reset", 32'(accel_reset), 32'd0);
        reset = 1'b1;
        #1;
        check("mid rst accel_reset", 32'(accel_reset), 32'd1);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst class_id", 32'(class_id), 32'hF);
        check("mid rst max_score", max_score, 32'd0);
        check("mid rst run_cycles", 32'(run_cycles), 32'd0);
        check("mid rst timed_out", 32'(timed_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[2], 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
